cl_frame_tx: RTL and testbench
==============================

// Module: cl_frame_tx
// PURPOSE
//  Camera Link-style frame transmitter. It drains a pixel stream (two 12-bit pixels per 24-bit beat)
//  from an upstream valid/ready source, e.g. a frame-buffer reader. It regenerates frame/line/data
//  timing (frame_valid, line_valid, new_frame, pixel_vld) so the capture/receive side can be driven.
//  It sits at the video-output end of the design and also serves as a loopback source for the capture path.
// PARAMETERS
//  PIX_PER_BEAT  2    pixels carried per 24-bit beat; column counter step
//  FV_SETUP      2    cycles of frame_valid high before the first line_valid (>=1)
//  H_BLANK       256  cycles of line_valid low between lines within a frame (>=1)
//  FV_HOLD       2    cycles of frame_valid high after the last line_valid (>=1)
//  V_BLANK       256  cycles of frame_valid low after a frame (>=1)
// PORTS
//  sys_clk      in   1   single clock for all logic
//  sys_rst_n    in   1   asynchronous, active-low reset
//  start        in   1   pulse: begin one frame (ignored while busy)
//  continuous   in   1   1 = start the next frame automatically after V_BLANK
//  imageWidth   in   16  pixels per line; latched at frame start
//  imageHeight  in   16  lines per frame; latched at frame start
//  s_pixel      in   24  upstream beat data ([11:0] first pixel, [23:12] second pixel)
//  s_valid      in   1   upstream beat valid
//  s_ready      out  1   beat accepted when s_valid & s_ready
//  frame_valid  out  1   FVAL
//  line_valid   out  1   LVAL
//  new_frame    out  1   one-cycle pulse on the first frame_valid cycle of each frame
//  pixel_vld    out  1   DVAL; pixel holds a beat
//  pixel        out  24  output beat
//  busy         out  1   state != IDLE
//  frame_done   out  1   one-cycle pulse on the last V_BLANK cycle
//  cfg_err      out  1   one-cycle pulse: start rejected for bad geometry
//  underrun     out  1   sticky: s_valid low while in LINE; cleared on accepted start
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): state IDLE, counters 0, all outputs 0, including s_ready/pixel.
//  FSM: IDLE -> FV_SETUP -> LINE -> (HBLANK -> LINE)* -> FV_HOLD -> VBLANK -> IDLE | FV_SETUP.
//  IDLE: on start, check geometry. Width==0, width % PIX_PER_BEAT != 0, or height==0 -> cfg_err pulse, stay IDLE.
//    Otherwise latch imageWidth/imageHeight, clear underrun, go to FV_SETUP.
//  FV_SETUP: hold FV_SETUP cycles, then go to LINE. LINE: s_ready=1 (combinational from state).
//    colCnt += PIX_PER_BEAT per handshake. A handshake with colCnt == width-PIX_PER_BEAT ends the line:
//    colCnt<=0 and lineCnt+=1. Exit to HBLANK, or to FV_HOLD if lineCnt == height-1.
//  HBLANK: hold H_BLANK cycles, then go to LINE. FV_HOLD: hold FV_HOLD cycles, then go to VBLANK.
//  VBLANK: hold V_BLANK cycles, pulse frame_done on the last cycle.
//    Then go to FV_SETUP if continuous=1 (re-latch geometry, new_frame again), else IDLE.
//    A bad geometry at a continuous restart is handled as for start (cfg_err, go to IDLE).
//  Outputs are registered, one cycle after the state/handshake that produces them:
//    frame_valid = reg(state in {FV_SETUP,LINE,HBLANK,FV_HOLD})
//    line_valid  = reg(state==LINE)
//    pixel_vld   = reg(s_valid & s_ready)
//    pixel       = reg(s_pixel) on handshake, else held
//    new_frame   = reg(transition into FV_SETUP)
//  The last beat of a line therefore appears with line_valid still high. There is no pixel_vld outside line_valid.
//  Underrun: s_valid=0 in LINE -> pixel_vld=0 that cycle, line_valid stays high, underrun<=1. The line is never truncated.
//  start while busy is ignored. continuous may change at any time; it is sampled only at the end of VBLANK.
//  Counters are 16 bits. Blank counters are $clog2(max param)+1 bits and reload to 0 on each state entry.
//  Reset mid-frame: all outputs drop to 0 immediately (async). The next frame requires a new start.
// TESTING
//  1) W=8,H=2, defaults except H_BLANK=4,V_BLANK=4, s_valid=1, start:
//     new_frame x1; frame_valid high 16 cycles; 2 line_valid bursts of 4; 8 pixel_vld; 4-cycle gap; 1 frame_done.
//  2) W=8,H=1, s_valid toggling 1,0,1,0: line_valid high 8 cycles, 4 pixel_vld beats, underrun=1; clears on next start.
//  3) start with W=7 or H=0 -> cfg_err pulse, busy stays 0, no frame_valid. Start with W=2,H=1 -> single-beat frame.
//  4) continuous=1, 3 frames of W=4,H=3, ramp data:
//     3 new_frame pulses spaced exactly 2+2+4+2+4+2+2+V_BLANK cycles; output data equals input order.
//  5) Assert sys_rst_n=0 mid-LINE -> all outputs 0 in the same cycle. Release, then start -> clean new frame from new_frame.
//  6) Extra start pulse during LINE -> ignored: exactly one frame_done, same geometry kept.

Source files
------------

// File: rtl/cl_frame_tx.sv
// cl_frame_tx: Camera Link-style frame transmitter.
// Drains two-pixel beats from a valid/ready source and regenerates
// frame_valid / line_valid / pixel_vld timing around them.
//
// Handshake: a beat moves when s_valid & s_ready are both high on a
// rising sys_clk edge. s_ready depends only on the FSM state (high in
// LINE), never on s_valid. The source may drop s_valid at any time; a
// LINE cycle without s_valid is an underrun, and the line stretches
// until its last beat arrives.
module cl_frame_tx #(
    parameter int PIX_PER_BEAT = 2,
    parameter int FV_SETUP     = 2,
    parameter int H_BLANK      = 256,
    parameter int FV_HOLD      = 2,
    parameter int V_BLANK      = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [15:0] imageWidth,
    input  logic [15:0] imageHeight,
    input  logic [23:0] s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        frame_valid,
    output logic        line_valid,
    output logic        new_frame,
    output logic        pixel_vld,
    output logic [23:0] pixel,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    output logic        underrun,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FV_SETUP = 3'd1;
    localparam logic [2:0] S_LINE     = 3'd2;
    localparam logic [2:0] S_HBLANK   = 3'd3;
    localparam logic [2:0] S_FV_HOLD  = 3'd4;
    localparam logic [2:0] S_VBLANK   = 3'd5;

    // Blank counter is wide enough for the longest hold interval.
    localparam int MAX_A = (FV_SETUP > H_BLANK) ? FV_SETUP : H_BLANK;
    localparam int MAX_B = (FV_HOLD > V_BLANK) ? FV_HOLD : V_BLANK;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] L_FVS_LAST  = CW'(FV_SETUP - 1);
    localparam logic [CW-1:0] L_HBL_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] L_FVH_LAST  = CW'(FV_HOLD - 1);
    localparam logic [CW-1:0] L_VBL_LAST  = CW'(V_BLANK - 1);
    localparam logic [15:0]   L_PPB       = 16'(PIX_PER_BEAT);

    logic [2:0]    r_state;
    logic [CW-1:0] r_blank_cnt;
    logic [15:0]   r_col_cnt;
    logic [15:0]   r_line_cnt;
    logic [15:0]   r_width;
    logic [15:0]   r_height;

    logic          r_frame_valid;
    logic          r_line_valid;
    logic          r_new_frame;
    logic          r_pixel_vld;
    logic [23:0]   r_pixel;
    logic          r_frame_done;
    logic          r_cfg_err;
    logic          r_underrun;

    logic [2:0]    w_state_nxt;
    logic          w_geom_ok;
    logic          w_hs;
    logic          w_accept;
    logic          w_latch;
    logic          w_reject;
    logic          w_line_end;

    assign w_geom_ok  = (imageWidth != 16'd0) &&
                        ((imageWidth % L_PPB) == 16'd0) &&
                        (imageHeight != 16'd0);
    assign w_hs       = (r_state == S_LINE) && s_valid;
    assign w_line_end = w_hs && (r_col_cnt == (r_width - L_PPB));

    // Next-state decode; also flags frame starts and geometry rejects.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_geom_ok) begin
                        w_state_nxt = S_FV_SETUP;
                        w_accept    = 1'b1;
                        w_latch     = 1'b1;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            S_FV_SETUP: begin
                if (r_blank_cnt == L_FVS_LAST) w_state_nxt = S_LINE;
            end
            S_LINE: begin
                if (w_line_end) begin
                    w_state_nxt = (r_line_cnt == (r_height - 16'd1)) ? S_FV_HOLD : S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (r_blank_cnt == L_HBL_LAST) w_state_nxt = S_LINE;
            end
            S_FV_HOLD: begin
                if (r_blank_cnt == L_FVH_LAST) w_state_nxt = S_VBLANK;
            end
            S_VBLANK: begin
                if (r_blank_cnt == L_VBL_LAST) begin
                    if (!continuous) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_geom_ok) begin
                        w_state_nxt = S_FV_SETUP;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_reject    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and blank counter; the counter restarts on every state change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_blank_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_blank_cnt <= '0;
            end else if (r_state != S_IDLE && r_state != S_LINE) begin
                r_blank_cnt <= r_blank_cnt + 1'b1;
            end
        end
    end

    // Geometry latch plus column/line position within the frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_width    <= '0;
            r_height   <= '0;
            r_col_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_latch) begin
            r_width    <= imageWidth;
            r_height   <= imageHeight;
            r_col_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_hs) begin
            if (w_line_end) begin
                r_col_cnt  <= '0;
                r_line_cnt <= r_line_cnt + 16'd1;
            end else begin
                r_col_cnt  <= r_col_cnt + L_PPB;
            end
        end
    end

    // Registered video timing and data, one cycle behind the state/handshake.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_valid <= 1'b0;
            r_line_valid  <= 1'b0;
            r_new_frame   <= 1'b0;
            r_pixel_vld   <= 1'b0;
            r_pixel       <= '0;
            r_frame_done  <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_frame_valid <= (r_state == S_FV_SETUP) || (r_state == S_LINE) ||
                             (r_state == S_HBLANK)   || (r_state == S_FV_HOLD);
            r_line_valid  <= (r_state == S_LINE);
            // First FV_SETUP cycle, so the pulse lines up with the rising frame_valid.
            r_new_frame   <= (r_state == S_FV_SETUP) && (r_blank_cnt == '0);
            r_pixel_vld   <= w_hs;
            if (w_hs) r_pixel <= s_pixel;
            r_frame_done  <= (r_state == S_VBLANK) && (r_blank_cnt == L_VBL_LAST);
            r_cfg_err     <= w_reject;
        end
    end

    // Sticky underrun flag, cleared when a start is accepted from IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_accept) begin
            r_underrun <= 1'b0;
        end else if ((r_state == S_LINE) && !s_valid) begin
            r_underrun <= 1'b1;
        end
    end

    assign s_ready     = (r_state == S_LINE);
    assign busy        = (r_state != S_IDLE);
    assign frame_valid = r_frame_valid;
    assign line_valid  = r_line_valid;
    assign new_frame   = r_new_frame;
    assign pixel_vld   = r_pixel_vld;
    assign pixel       = r_pixel;
    assign frame_done  = r_frame_done;
    assign cfg_err     = r_cfg_err;
    assign underrun    = r_underrun;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cl_frame_tx.sv
// Bench for cl_frame_tx: a driver feeds ramp beats, a monitor pops the
// expected-beat queue on every pixel_vld and tallies the timing signals.
module tb_cl_frame_tx;

  logic        clk;
  logic        sys_rst_n;
  logic        start;
  logic        continuous;
  logic [15:0] imageWidth;
  logic [15:0] imageHeight;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic        frame_valid;
  logic        line_valid;
  logic        new_frame;
  logic        pixel_vld;
  logic [23:0] pixel;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;
  logic        underrun;
  logic [2:0]  dbg_state;

  cl_frame_tx #(
    .PIX_PER_BEAT(2),
    .FV_SETUP(2),
    .H_BLANK(4),
    .FV_HOLD(2),
    .V_BLANK(4)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(sys_rst_n),
    .start(start),
    .continuous(continuous),
    .imageWidth(imageWidth),
    .imageHeight(imageHeight),
    .s_pixel(s_pixel),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .frame_valid(frame_valid),
    .line_valid(line_valid),
    .new_frame(new_frame),
    .pixel_vld(pixel_vld),
    .pixel(pixel),
    .busy(busy),
    .frame_done(frame_done),
    .cfg_err(cfg_err),
    .underrun(underrun),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int nf_t[$];
  int n_nf, n_fv, n_lv, n_lvb, n_fvnl, n_dv, n_fd, n_cfg;
  int n_nf_bad = 0;
  int cyc = 0;
  logic fv_prev = 1'b0;
  logic lv_prev = 1'b0;

  int drv_mode = 0;   // 0 idle, 1 always valid, 2 toggle while ready
  logic tog = 1'b0;
  int beat_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_nf = 0; n_fv = 0; n_lv = 0; n_lvb = 0; n_fvnl = 0;
    n_dv = 0; n_fd = 0; n_cfg = 0;
    nf_t.delete();
  endtask

  // ---------------- driver ----------------
  initial begin
    logic [11:0] p0;
    logic [11:0] p1;
    s_valid = 1'b0;
    s_pixel = '0;
    forever begin
      @(negedge clk);
      case (drv_mode)
        1: s_valid = 1'b1;
        2: begin
          if (s_ready) begin
            s_valid = tog;
            tog = ~tog;
          end else begin
            s_valid = 1'b0;
          end
        end
        default: s_valid = 1'b0;
      endcase
      p0 = 12'(beat_no * 2);
      p1 = 12'(beat_no * 2 + 1);
      s_pixel = {p1, p0};
      if (s_valid && s_ready && sys_rst_n) begin
        exp_q.push_back(s_pixel);
        beat_no++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] e;
    clear_counts();
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_valid) n_fv++;
      if (line_valid) n_lv++;
      if (line_valid && !lv_prev) n_lvb++;
      if (frame_valid && !line_valid) n_fvnl++;
      if (new_frame) begin
        n_nf++;
        nf_t.push_back(cyc);
      end
      if (new_frame != (frame_valid && !fv_prev)) n_nf_bad++;
      if (frame_done) n_fd++;
      if (cfg_err) n_cfg++;
      if (pixel_vld) begin
        n_dv++;
        check("dval_in_lval", {31'd0, line_valid}, 32'd1);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_unexpected: got %06h expected none", pixel);
        end else begin
          e = exp_q.pop_front();
          if (pixel !== e) begin
            n_fail++;
            $display("FAIL pixel_data: got %06h expected %06h", pixel, e);
          end
        end
      end
      fv_prev = frame_valid;
      lv_prev = line_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] w, input logic [15:0] h);
    step(1);
    imageWidth  = w;
    imageHeight = h;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int k = 0;
    while (n_fd < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_fd < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame_done count %0d, wanted %0d within %0d cycles", name, n_fd, target, budget);
    end
  endtask

  task automatic wait_lv(input int budget, input string name);
    int k = 0;
    while (!line_valid && k < budget) begin
      step(1);
      k++;
    end
    if (!line_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: line_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    sys_rst_n   = 1'b0;
    start       = 1'b0;
    continuous  = 1'b0;
    imageWidth  = 16'd0;
    imageHeight = 16'd0;
    #23;
    check("reset_ctrl", {23'd0, frame_valid, line_valid, new_frame, pixel_vld, busy,
                         frame_done, cfg_err, underrun, s_ready}, 32'd0);
    check("reset_pixel", {8'd0, pixel}, 32'd0);
    sys_rst_n = 1'b1;
    step(2);

    // 1) W=8 H=2 continuous valid
    drv_mode = 1;
    clear_counts();
    do_start(16'd8, 16'd2);
    wait_fd(1, 200, "t1_done");
    step(3);
    check("t1_new_frame", n_nf, 1);
    check("t1_fv_cycles", n_fv, 16);
    check("t1_lv_bursts", n_lvb, 2);
    check("t1_lv_cycles", n_lv, 8);
    check("t1_dval", n_dv, 8);
    check("t1_fv_no_lv", n_fvnl, 8);
    check("t1_frame_done", n_fd, 1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2) W=8 H=1 toggling valid: underrun
    drv_mode = 2;
    tog = 1'b0;
    clear_counts();
    do_start(16'd8, 16'd1);
    wait_fd(1, 200, "t2_done");
    step(3);
    check("t2_lv_cycles", n_lv, 8);
    check("t2_dval", n_dv, 4);
    check("t2_underrun", {31'd0, underrun}, 32'd1);

    // 3) bad geometry, then single-beat frame
    drv_mode = 1;
    clear_counts();
    do_start(16'd7, 16'd1);
    check("t3_busy_w7", {31'd0, busy}, 32'd0);
    step(4);
    do_start(16'd4, 16'd0);
    check("t3_busy_h0", {31'd0, busy}, 32'd0);
    step(4);
    do_start(16'd0, 16'd3);
    step(4);
    check("t3_cfg_err", n_cfg, 3);
    check("t3_no_fv", n_fv, 0);
    check("t3_underrun_kept", {31'd0, underrun}, 32'd1);
    clear_counts();
    do_start(16'd2, 16'd1);
    wait_fd(1, 200, "t3_done");
    step(3);
    check("t3_single_dval", n_dv, 1);
    check("t3_single_lv", n_lv, 1);
    check("t3_single_fv", n_fv, 5);
    check("t3_underrun_clr", {31'd0, underrun}, 32'd0);

    // 4) continuous, 3 frames of W=4 H=3
    clear_counts();
    continuous = 1'b1;
    do_start(16'd4, 16'd3);
    begin
      int k = 0;
      while (n_nf < 3 && k < 300) begin
        step(1);
        k++;
      end
    end
    continuous = 1'b0;
    wait_fd(3, 300, "t4_done");
    step(10);
    check("t4_new_frames", n_nf, 3);
    if (nf_t.size() >= 3) begin
      check("t4_spacing_a", nf_t[1] - nf_t[0], 22);
      check("t4_spacing_b", nf_t[2] - nf_t[1], 22);
    end
    check("t4_dval", n_dv, 18);
    check("t4_frame_done", n_fd, 3);
    check("t4_busy_end", {31'd0, busy}, 32'd0);

    // 5) reset mid-line
    clear_counts();
    do_start(16'd8, 16'd2);
    wait_lv(50, "t5_lv");
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("t5_reset_ctrl", {23'd0, frame_valid, line_valid, new_frame, pixel_vld, busy,
                            frame_done, cfg_err, underrun, s_ready}, 32'd0);
    check("t5_reset_pixel", {8'd0, pixel}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2;
    sys_rst_n = 1'b1;
    clear_counts();
    step(10);
    check("t5_idle_after_rst", n_fv, 0);
    do_start(16'd4, 16'd1);
    wait_fd(1, 200, "t5_done");
    step(3);
    check("t5_new_frame", n_nf, 1);
    check("t5_fv_cycles", n_fv, 6);
    check("t5_dval", n_dv, 2);

    // 6) extra start during LINE is ignored
    clear_counts();
    do_start(16'd8, 16'd2);
    wait_lv(50, "t6_lv");
    do_start(16'd4, 16'd1);
    wait_fd(1, 200, "t6_done");
    step(30);
    check("t6_frame_done", n_fd, 1);
    check("t6_dval", n_dv, 8);
    check("t6_fv_cycles", n_fv, 16);
    check("t6_busy_end", {31'd0, busy}, 32'd0);

    drv_mode = 0;
    step(3);
    check("queue_empty", exp_q.size(), 0);
    check("nf_align", n_nf_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
